// File: rtl/chan_mux_demux_pkg.sv
// Shared types and helpers for the channel mux/demux slice.
package chan_mux_demux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_e;

  // Index width for n channels; never zero so a 1-bit select always exists.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/chan_mux_demux_if.sv
// Handshake bundle for chan_mux_demux: slave is the block's view, master the environment's.
interface chan_mux_demux_if #(
  parameter int NCH = 4,
  parameter int DW  = 8
);
  import chan_mux_demux_pkg::*;

  localparam int SELW = clog2_min1(NCH);

  logic                mux_mode;
  logic [SELW-1:0]     mux_sel;
  logic [NCH-1:0]      mux_in_valid;
  logic [NCH*DW-1:0]   mux_in_data;
  logic [NCH-1:0]      mux_in_ready;
  logic                mux_out_valid;
  logic [DW-1:0]       mux_out_data;
  logic [SELW-1:0]     mux_out_ch;
  logic                mux_out_ready;

  logic                dmx_in_valid;
  logic [DW-1:0]       dmx_in_data;
  logic [SELW-1:0]     dmx_in_sel;
  logic                dmx_in_ready;
  logic [NCH-1:0]      dmx_out_valid;
  logic [DW-1:0]       dmx_out_data;
  logic [NCH-1:0]      dmx_out_ready;
  logic                dmx_err;

  modport slave (
    input  mux_mode, mux_sel, mux_in_valid, mux_in_data, mux_out_ready,
    output mux_in_ready, mux_out_valid, mux_out_data, mux_out_ch,
    input  dmx_in_valid, dmx_in_data, dmx_in_sel, dmx_out_ready,
    output dmx_in_ready, dmx_out_valid, dmx_out_data, dmx_err
  );

  modport master (
    output mux_mode, mux_sel, mux_in_valid, mux_in_data, mux_out_ready,
    input  mux_in_ready, mux_out_valid, mux_out_data, mux_out_ch,
    output dmx_in_valid, dmx_in_data, dmx_in_sel, dmx_out_ready,
    input  dmx_in_ready, dmx_out_valid, dmx_out_data, dmx_err
  );

endinterface

// File: rtl/chan_mux_demux_rr_arbiter.sv
// Round-robin arbiter: first requester searching upward from ptr+1, modulo NCH.
module cmd_rr_arbiter
  import chan_mux_demux_pkg::*;
#(
  parameter int NCH = 4,
  localparam int SELW = clog2_min1(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_vld
);

  // Scan from farthest to nearest so the nearest requester after ptr wins.
  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt_idx = {SELW{1'b0}};
    idx     = 0;
    for (int k = NCH; k >= 1; k--) begin
      idx     = (int'(ptr) + k) % NCH;
      gnt_vld = req[idx] ? 1'b1 : gnt_vld;
      gnt_idx = req[idx] ? SELW'(idx) : gnt_idx;
    end
  end

endmodule

// File: rtl/chan_mux_demux.sv
// Registered NCH:1 mux and 1:NCH demux with valid/ready handshakes.
// Optional round-robin mux arbitration is built under CHAN_MUX_DEMUX_RR_EN.
module chan_mux_demux
  import chan_mux_demux_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DW  = 8
) (
  input  logic            clk,
  input  logic            rst,
  chan_mux_demux_if.slave bus
);

  localparam int              SELW  = clog2_min1(NCH);
  localparam logic [SELW:0]   NCH_L = (SELW+1)'(NCH);
  localparam logic [NCH-1:0]  ONE_L = {{(NCH-1){1'b0}}, 1'b1};

  logic            mux_out_valid_q, mux_out_valid_d;
  logic [DW-1:0]   mux_out_data_q, mux_out_data_d;
  logic [SELW-1:0] mux_out_ch_q, mux_out_ch_d;
  logic            load_s, xfer_s, fix_vld_s, gnt_vld_s, sel_valid_s;
  logic [SELW-1:0] gnt_idx_s;
  logic [DW-1:0]   sel_data_s;
  logic [NCH-1:0]  mux_in_ready_s;

  assign fix_vld_s = ({1'b0, bus.mux_sel} < NCH_L);

`ifdef CHAN_MUX_DEMUX_RR_EN
  logic [SELW-1:0] rr_ptr_q, rr_ptr_d, arb_idx_s;
  logic            arb_vld_s;

  cmd_rr_arbiter #(.NCH(NCH)) u_arb (
    .req     (bus.mux_in_valid),
    .ptr     (rr_ptr_q),
    .gnt_idx (arb_idx_s),
    .gnt_vld (arb_vld_s)
  );

  // Grant source: arbiter in round-robin mode, mux_sel otherwise.
  always_comb begin
    if (bus.mux_mode == MODE_RR) begin
      gnt_vld_s = arb_vld_s;
      gnt_idx_s = arb_idx_s;
    end else begin
      gnt_vld_s = fix_vld_s;
      gnt_idx_s = bus.mux_sel;
    end
  end

  // Pointer follows the last transferred channel.
  always_comb begin
    rr_ptr_d = xfer_s ? gnt_idx_s : rr_ptr_q;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= SELW'(NCH - 1);
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  logic unused_mode_s;
  assign unused_mode_s = bus.mux_mode;
  assign gnt_vld_s     = fix_vld_s;
  assign gnt_idx_s     = bus.mux_sel;
`endif

  // Pick the granted channel's valid/data and build the per-channel ready.
  always_comb begin
    sel_valid_s    = 1'b0;
    sel_data_s     = {DW{1'b0}};
    mux_in_ready_s = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      sel_valid_s       = (gnt_idx_s == SELW'(i)) ? bus.mux_in_valid[i] : sel_valid_s;
      sel_data_s        = (gnt_idx_s == SELW'(i)) ? bus.mux_in_data[i*DW +: DW] : sel_data_s;
      mux_in_ready_s[i] = load_s && gnt_vld_s && (gnt_idx_s == SELW'(i));
    end
  end

  assign load_s = !mux_out_valid_q || bus.mux_out_ready;
  assign xfer_s = load_s && gnt_vld_s && sel_valid_s;

  // Mux output register next state; a stalled beat is never touched.
  always_comb begin
    mux_out_valid_d = mux_out_valid_q;
    mux_out_data_d  = mux_out_data_q;
    mux_out_ch_d    = mux_out_ch_q;
    if (load_s) begin
      mux_out_valid_d = xfer_s;
      if (xfer_s) begin
        mux_out_data_d = sel_data_s;
        mux_out_ch_d   = gnt_idx_s;
      end else begin
        mux_out_data_d = mux_out_data_q;
        mux_out_ch_d   = mux_out_ch_q;
      end
    end else begin
      mux_out_valid_d = mux_out_valid_q;
    end
  end

  // Mux output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mux_out_valid_q <= 1'b0;
      mux_out_data_q  <= {DW{1'b0}};
      mux_out_ch_q    <= {SELW{1'b0}};
    end else begin
      mux_out_valid_q <= mux_out_valid_d;
      mux_out_data_q  <= mux_out_data_d;
      mux_out_ch_q    <= mux_out_ch_d;
    end
  end

  logic [NCH-1:0]  dmx_out_valid_q, dmx_out_valid_d;
  logic [DW-1:0]   dmx_out_data_q, dmx_out_data_d;
  logic [SELW-1:0] held_ch_q, held_ch_d;
  logic            dmx_err_q, dmx_err_d;
  logic            held_rdy_s, dmx_in_ready_s, accept_s, in_range_s;

  // Only the held channel's ready can release the demux register.
  always_comb begin
    held_rdy_s = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      held_rdy_s = (held_ch_q == SELW'(i)) ? bus.dmx_out_ready[i] : held_rdy_s;
    end
  end

  assign dmx_in_ready_s = !(|dmx_out_valid_q) || held_rdy_s;
  assign accept_s       = bus.dmx_in_valid && dmx_in_ready_s;
  assign in_range_s     = ({1'b0, bus.dmx_in_sel} < NCH_L);

  // Demux next state; out-of-range beats are consumed and only flag dmx_err.
  always_comb begin
    dmx_out_valid_d = dmx_out_valid_q;
    dmx_out_data_d  = dmx_out_data_q;
    held_ch_d       = held_ch_q;
    dmx_err_d       = dmx_err_q || (accept_s && !in_range_s);
    if (dmx_in_ready_s) begin
      if (accept_s && in_range_s) begin
        dmx_out_valid_d = ONE_L << bus.dmx_in_sel;
        dmx_out_data_d  = bus.dmx_in_data;
        held_ch_d       = bus.dmx_in_sel;
      end else begin
        dmx_out_valid_d = {NCH{1'b0}};
      end
    end else begin
      dmx_out_valid_d = dmx_out_valid_q;
    end
  end

  // Demux output register and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmx_out_valid_q <= {NCH{1'b0}};
      dmx_out_data_q  <= {DW{1'b0}};
      held_ch_q       <= {SELW{1'b0}};
      dmx_err_q       <= 1'b0;
    end else begin
      dmx_out_valid_q <= dmx_out_valid_d;
      dmx_out_data_q  <= dmx_out_data_d;
      held_ch_q       <= held_ch_d;
      dmx_err_q       <= dmx_err_d;
    end
  end

  assign bus.mux_in_ready  = mux_in_ready_s;
  assign bus.mux_out_valid = mux_out_valid_q;
  assign bus.mux_out_data  = mux_out_data_q;
  assign bus.mux_out_ch    = mux_out_ch_q;
  assign bus.dmx_in_ready  = dmx_in_ready_s;
  assign bus.dmx_out_valid = dmx_out_valid_q;
  assign bus.dmx_out_data  = dmx_out_data_q;
  assign bus.dmx_err       = dmx_err_q;

endmodule
